mix_columns_seq: RTL and testbench
==================================

Name: mix_columns_seq

Overview:
- Sequential, parametrised successor to the combinational AES MixColumns stage.
- Accepts a 128-bit AES state over a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock.
- Supports both forward MixColumns (encryption) and InvMixColumns (decryption), selected per transaction.
- Sits between ShiftRows/InvShiftRows and AddRoundKey in the iterative round datapath, trading throughput for area.

Parameters:
- COLS_PER_CYCLE, 1: columns processed per RUN cycle; legal values 1, 2, 4; other values are an elaboration error.
- INVERSE_EN, 1: 1 instantiates InvMixColumns logic; 0 removes it, the `inverse` input is ignored and every transaction is forward.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  state_in/inverse are valid.
- in_ready  output  1  block can accept a state this cycle.
- inverse  input  1  0 = MixColumns, 1 = InvMixColumns; sampled on accept.
- state_in  input  128  input state; column c = bits [127-32c -: 32]; row 0 byte in the MSB of each column.
- out_valid  output  1  state_out holds a completed result.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  result, same byte ordering as state_in; registered.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clock edge), including mid-operation:
  - FSM goes to IDLE; out_valid=0, busy=0, state_out=128'h0, column counter=0, mode latch=0.
  - Any transaction in flight is discarded without output.
  - rst has priority over every other input in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch state_in into the working register, latch mode = inverse & INVERSE_EN, clear the counter, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle, transform columns [cnt .. cnt+COLS_PER_CYCLE-1] of the working register in place; cnt += COLS_PER_CYCLE.
  - When the last column is written: copy the working result to state_out, set out_valid=1, go to DONE.
  - RUN lasts exactly 4/COLS_PER_CYCLE cycles.
- Latency: accept at edge k → out_valid first high after edge k+4/COLS_PER_CYCLE, i.e. 4, 2 or 1 cycles.
- DONE:
  - out_valid=1; state_out is stable until the handshake.
  - out_ready=0 holds DONE indefinitely (backpressure); no new state is accepted.
  - On out_valid&out_ready: out_valid falls at that edge.
  - in_ready = out_ready in DONE (combinational). A simultaneous in_valid starts the next transaction at the same edge (DONE→RUN), giving back-to-back throughput of one state per 4/COLS_PER_CYCLE+1 cycles.
  - If no new input arrives at the handshake edge, go to IDLE.
- state_out keeps the last result after the handshake, until the next completion or reset.
- Forward column transform, per output byte r:
  - out[r] = 2·a[r] ^ 3·a[r+1] ^ a[r+2] ^ a[r+3] (indices mod 4).
- Inverse column transform, per output byte r:
  - out[r] = 14·a[r] ^ 11·a[r+1] ^ 13·a[r+2] ^ 9·a[r+3].
- GF(2^8) arithmetic: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); all products are built from xtime chains and XOR.
- Mode change on `inverse` while in RUN/DONE has no effect on the current transaction.
- The same column never appears in two RUN cycles of one transaction; columns are processed in order 0..3.

Test Plan:
1. Forward, COLS_PER_CYCLE=1, inverse=0, state_in=D4BF5D30E0B452AEB84111F11E2798E5 → out_valid exactly 4 cycles after accept, state_out=046681E5E0CB199A48F8D37A2806264C.
2. Inverse, INVERSE_EN=1, inverse=1, state_in=046681E5E0CB199A48F8D37A2806264C → state_out=D4BF5D30E0B452AEB84111F11E2798E5. With INVERSE_EN=0 and the same stimulus → forward result instead.
3. COLS_PER_CYCLE=4 and 2, state_in=DB135345F20A225C01010101C6C6C6C6 → state_out=8E4DA1BC9FDC589D01010101C6C6C6C6 with latency 1 and 2 respectively.
4. Backpressure: hold out_ready=0 for 10 cycles after completion → out_valid stays 1, state_out stable, in_ready=0. Then raise out_ready together with in_valid (new state 01010101…) → both handshakes at the same edge, and the next result appears after the expected latency.
5. Reset mid-RUN: assert rst in the 2nd RUN cycle → next cycle IDLE, out_valid=0, state_out=0, in_ready=1; a following transaction of vector 1 completes correctly.
6. Back-to-back random states in alternating modes, checked against a reference model; in_valid asserted during RUN must not be accepted.

Source files
------------

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns: a 128-bit state is accepted over a
// valid/ready handshake and transformed COLS_PER_CYCLE columns per clock.

module mix_columns_lane #(
  parameter bit INVERSE_EN = 1'b1
) (
  input  logic        inv,
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Row 0 lives in the top byte, so row r sits at byte index 3-r.
  logic [3:0][7:0] a, x2, x4, x8, ob;
  logic [1:0] j0, j1, j2, j3;

  assign a       = col_in;
  assign col_out = ob;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      x2[k] = xt(a[k]);
      x4[k] = xt(x2[k]);
      x8[k] = xt(x4[k]);
    end
  end

  always_comb begin
    ob = '0;
    j0 = '0; j1 = '0; j2 = '0; j3 = '0;
    for (int r = 0; r < 4; r++) begin
      j0 = 2'(3 - r);
      j1 = j0 - 2'd1;
      j2 = j0 - 2'd2;
      j3 = j0 - 2'd3;
      if (INVERSE_EN && inv)
        ob[j0] = (x8[j0] ^ x4[j0] ^ x2[j0]) ^ (x8[j1] ^ x2[j1] ^ a[j1]) ^
                 (x8[j2] ^ x4[j2] ^ a[j2]) ^ (x8[j3] ^ a[j3]);
      else
        ob[j0] = x2[j0] ^ x2[j1] ^ a[j1] ^ a[j2] ^ a[j3];
    end
  end
endmodule

module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INVERSE_EN     = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inverse,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, st_nxt;

  // Column c of the state is work[3-c], i.e. work[~c] for a 2-bit column number.
  logic [3:0][31:0] work, work_nxt;
  logic [1:0]       cnt;
  logic             mode, accept, last;
  logic [COLS_PER_CYCLE-1:0][1:0]  idx;
  logic [COLS_PER_CYCLE-1:0][31:0] lane_in, lane_out;

  assign in_ready  = (st == IDLE) || (st == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST);
  assign out_valid = (st == DONE);
  assign busy      = (st != IDLE);

  for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
    assign idx[l]     = cnt + 2'(l);
    assign lane_in[l] = work[~idx[l]];
    mix_columns_lane #(.INVERSE_EN(INVERSE_EN)) u_lane (
      .inv    (mode),
      .col_in (lane_in[l]),
      .col_out(lane_out[l])
    );
  end

  always_comb begin
    work_nxt = work;
    for (int l = 0; l < COLS_PER_CYCLE; l++)
      work_nxt[~idx[l]] = lane_out[l];
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (in_valid) st_nxt = RUN;
      RUN:     if (last) st_nxt = DONE;
      DONE:    if (out_ready) st_nxt = in_valid ? RUN : IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= '0;
      cnt       <= '0;
      mode      <= 1'b0;
      state_out <= '0;
    end else if (accept) begin
      work <= state_in;
      mode <= inverse & INVERSE_EN;
      cnt  <= '0;
    end else if (st == RUN) begin
      work <= work_nxt;
      cnt  <= cnt + STEP;
      if (last) state_out <= work_nxt;
    end
  end
endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: four configurations share one stimulus stream and are
// compared every cycle against a transaction-level GF(2^8) reference model.

module tb_mix_columns_seq;
  localparam logic [127:0] V1 = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
  localparam logic [127:0] R1 = 128'h046681E5E0CB199A48F8D37A2806264C;
  localparam logic [127:0] V3 = 128'hDB135345F20A225C01010101C6C6C6C6;
  localparam logic [127:0] R3 = 128'h8E4DA1BC9FDC589D01010101C6C6C6C6;
  localparam logic [127:0] V4 = 128'h01010101010101010101010101010101;

  // Instances: 0 = 1 col/cycle, 1 = 2 col/cycle, 2 = 4 col/cycle, 3 = forward only.
  localparam int LAT [4] = '{4, 2, 1, 4};
  localparam bit IEN [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1, in_valid = 1'b0, inverse = 1'b0, out_ready = 1'b1;
  logic [127:0] state_in = '0;
  logic ir [4], ov [4], bsy [4];
  logic [127:0] so [4];

  always #5 clk = ~clk;

  mix_columns_seq #(.COLS_PER_CYCLE(1), .INVERSE_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .inverse(inverse),
    .state_in(state_in), .out_valid(ov[0]), .out_ready(out_ready), .state_out(so[0]), .busy(bsy[0]));
  mix_columns_seq #(.COLS_PER_CYCLE(2), .INVERSE_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .inverse(inverse),
    .state_in(state_in), .out_valid(ov[1]), .out_ready(out_ready), .state_out(so[1]), .busy(bsy[1]));
  mix_columns_seq #(.COLS_PER_CYCLE(4), .INVERSE_EN(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .inverse(inverse),
    .state_in(state_in), .out_valid(ov[2]), .out_ready(out_ready), .state_out(so[2]), .busy(bsy[2]));
  mix_columns_seq #(.COLS_PER_CYCLE(1), .INVERSE_EN(1'b0)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .inverse(inverse),
    .state_in(state_in), .out_valid(ov[3]), .out_ready(out_ready), .state_out(so[3]), .busy(bsy[3]));

  // Reference: textbook GF(2^8) multiply and matrix-times-column.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mixref(input logic [127:0] s, input bit inv);
    logic [3:0] coef [4];
    logic [127:0] r;
    logic [7:0] acc;
    if (inv) coef = '{4'd14, 4'd11, 4'd13, 4'd9};
    else     coef = '{4'd2, 4'd3, 4'd1, 4'd1};
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127 - 32*c - 8*((row + k) % 4) -: 8], coef[k]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    return r;
  endfunction

  // Model state per instance: cycles left in the transform, result waiting for handshake.
  int run_left [4];
  bit mdone [4];
  bit acc_now [4];
  logic [127:0] pend [4], mout [4];
  bit chk_on = 1'b0;
  bit finish_req = 1'b0;
  int total = 0, bad = 0;

  function automatic bit exp_ir(input int i);
    return run_left[i] == 0 && (!mdone[i] || out_ready);
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      run_left[i] = 0; mdone[i] = 1'b0; pend[i] = '0; mout[i] = '0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 4; i++) acc_now[i] = in_valid && exp_ir(i);
      for (int i = 0; i < 4; i++) begin
        if (rst) begin
          run_left[i] = 0; mdone[i] = 1'b0; mout[i] = '0;
        end else begin
          if (run_left[i] > 0) begin
            run_left[i] = run_left[i] - 1;
            if (run_left[i] == 0) begin
              mdone[i] = 1'b1;
              mout[i]  = pend[i];
            end
          end else if (mdone[i] && out_ready) begin
            mdone[i] = 1'b0;
          end
          if (acc_now[i]) begin
            pend[i]     = mixref(state_in, inverse && IEN[i]);
            run_left[i] = LAT[i];
          end
        end
      end
      if (rst) chk_on = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: pins the model to known vectors, then checks every cycle.
  initial begin
    chk("ref_fwd_v1", mixref(V1, 1'b0), R1);
    chk("ref_inv_r1", mixref(R1, 1'b1), V1);
    chk("ref_fwd_v3", mixref(V3, 1'b0), R3);
    chk("ref_fwd_ones", mixref(V4, 1'b0), V4);
    chk("ref_inv_ones", mixref(V4, 1'b1), V4);
    forever begin
      @(negedge clk);
      if (chk_on)
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("u%0d.in_ready", i), 128'(ir[i]), 128'(exp_ir(i)));
          chk($sformatf("u%0d.out_valid", i), 128'(ov[i]), 128'(mdone[i]));
          chk($sformatf("u%0d.busy", i), 128'(bsy[i]), 128'(run_left[i] > 0 || mdone[i]));
          chk($sformatf("u%0d.state_out", i), so[i], mout[i]);
        end
      if (finish_req) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [127:0] s, input logic inv);
    state_in = s;
    inverse  = inv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    tick();

    // Known-answer vectors in both directions and the mixed-column vector.
    send(V1, 1'b0); tick(6);
    send(R1, 1'b1); tick(6);
    send(V3, 1'b0); tick(6);

    // Backpressure with a pending request that must wait for the output handshake.
    out_ready = 1'b0;
    send(V1, 1'b0); tick(4);
    state_in = V4; inverse = 1'b0; in_valid = 1'b1;
    tick(10);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(6);

    // Reset during the second RUN cycle, then a clean transaction.
    send(V1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(2);
    send(V1, 1'b0); tick(6);

    // Random back-to-back traffic, alternating mode, random output stalls.
    for (int n = 0; n < 120; n++) begin
      in_valid  = ($urandom_range(0, 4) != 0);
      state_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
      inverse   = n[0];
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(8);
    finish_req = 1'b1;
  end
endmodule
